// File: rtl/shift_reg_universal.sv
// Universal bidirectional shift register with parallel load and frame counting.
// Optional rotate mode is built when SHIFT_ROTATE_EN is defined.
module shift_reg_universal #(
  parameter int WIDTH     = 8,
  parameter int FRAME_LEN = WIDTH,
  localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic             i_dir,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_parallel_in,
  input  logic             i_serial_in,
`ifdef SHIFT_ROTATE_EN
  input  logic             i_rotate,
`endif
  output logic             o_serial_out,
  output logic [WIDTH-1:0] o_parallel_out,
  output logic [CW-1:0]    o_count,
  output logic             o_frame_done
);

  logic [WIDTH-1:0] r_reg;
  logic [CW-1:0]    r_count;
  logic             r_frame_done;

  logic             w_in;
  logic             w_last;
  logic [WIDTH-1:0] w_next;

`ifdef SHIFT_ROTATE_EN
  // Rotation feeds back the bit falling off the opposite end.
  assign w_in = i_rotate ? (i_dir ? r_reg[0] : r_reg[WIDTH-1])
                         : i_serial_in;
`else
  assign w_in = i_serial_in;
`endif

  assign w_next = i_dir ? {w_in, r_reg[WIDTH-1:1]}
                        : {r_reg[WIDTH-2:0], w_in};

  assign w_last = (r_count == CW'(FRAME_LEN - 1));

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_reg        <= '0;
      r_count      <= '0;
      r_frame_done <= 1'b0;
    end else if (i_load) begin
      r_reg        <= i_parallel_in;
      r_count      <= '0;
      r_frame_done <= 1'b0;
    end else if (i_enable) begin
      r_reg        <= w_next;
      r_count      <= w_last ? '0 : r_count + CW'(1);
      r_frame_done <= w_last;
    end else begin
      r_frame_done <= 1'b0;
    end
  end

  // Forced low while reset is held so the line is quiet before first edge.
  assign o_serial_out   = i_reset & (i_dir ? r_reg[0] : r_reg[WIDTH-1]);
  assign o_parallel_out = r_reg;
  assign o_count        = r_count;
  assign o_frame_done   = r_frame_done;

endmodule

// File: tb/tb_shift_reg_universal.sv
// Randomised bench for shift_reg_universal against a behavioural model.
// Three instances share stimulus: FRAME_LEN 8, 3 and 1.
module tb_shift_reg_universal;

  logic       clk = 1'b0;
  logic       reset, enable, dir, load, serial_in, rotate;
  logic [7:0] parallel_in;

  logic       so   [3];
  logic [7:0] po   [3];
  logic       fd   [3];
  logic [2:0] cnt0;
  logic [1:0] cnt1;
  logic [0:0] cnt2;

  int total = 0;
  int bad   = 0;

  logic [7:0] m_reg;
  int         m_cnt [3];
  bit         m_fd  [3];
  bit         mvalid = 0;
  int         FL [3] = '{8, 3, 1};

  always #5 clk = ~clk;

`ifdef SHIFT_ROTATE_EN
  `define ROT_PORT .i_rotate(rotate),
`else
  `define ROT_PORT
`endif

  shift_reg_universal #(.WIDTH(8), .FRAME_LEN(8)) u0 (
    .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_dir(dir),
    .i_load(load), .i_parallel_in(parallel_in), .i_serial_in(serial_in),
    `ROT_PORT
    .o_serial_out(so[0]), .o_parallel_out(po[0]),
    .o_count(cnt0), .o_frame_done(fd[0]));

  shift_reg_universal #(.WIDTH(8), .FRAME_LEN(3)) u1 (
    .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_dir(dir),
    .i_load(load), .i_parallel_in(parallel_in), .i_serial_in(serial_in),
    `ROT_PORT
    .o_serial_out(so[1]), .o_parallel_out(po[1]),
    .o_count(cnt1), .o_frame_done(fd[1]));

  shift_reg_universal #(.WIDTH(8), .FRAME_LEN(1)) u2 (
    .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_dir(dir),
    .i_load(load), .i_parallel_in(parallel_in), .i_serial_in(serial_in),
    `ROT_PORT
    .o_serial_out(so[2]), .o_parallel_out(po[2]),
    .o_count(cnt2), .o_frame_done(fd[2]));

  function automatic int dut_cnt(input int i);
    case (i)
      0: return int'(cnt0);
      1: return int'(cnt1);
      default: return int'(cnt2);
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (mvalid) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("po[%0d]", i), int'(po[i]), int'(m_reg));
        chk($sformatf("cnt[%0d]", i), dut_cnt(i), m_cnt[i]);
        chk($sformatf("fd[%0d]", i), int'(fd[i]), int'(m_fd[i]));
        chk($sformatf("so[%0d]", i), int'(so[i]),
            !reset ? 0 : (dir ? int'(m_reg[0]) : int'(m_reg[7])));
      end
    end
  end

  task automatic step(input logic rst, input logic ld, input logic en,
                      input logic d, input logic sin, input logic rot,
                      input logic [7:0] pin);
    bit b;
    reset = rst; load = ld; enable = en; dir = d;
    serial_in = sin; rotate = rot; parallel_in = pin;
    @(posedge clk);
    if (!rst) begin
      m_reg = 8'h00;
      for (int i = 0; i < 3; i++) begin m_cnt[i] = 0; m_fd[i] = 0; end
      mvalid = 1;
    end else if (ld) begin
      m_reg = pin;
      for (int i = 0; i < 3; i++) begin m_cnt[i] = 0; m_fd[i] = 0; end
    end else if (en) begin
      b = sin;
`ifdef SHIFT_ROTATE_EN
      if (rot) b = d ? m_reg[0] : m_reg[7];
`endif
      if (d) m_reg = (m_reg >> 1) | (8'(b) << 7);
      else   m_reg = 8'((m_reg << 1) | 8'(b));
      for (int i = 0; i < 3; i++) begin
        if (m_cnt[i] + 1 == FL[i]) begin m_cnt[i] = 0; m_fd[i] = 1; end
        else begin m_cnt[i]++; m_fd[i] = 0; end
      end
    end else begin
      for (int i = 0; i < 3; i++) m_fd[i] = 0;
    end
    @(negedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] seq;
    logic [7:0] din;
    int pulses;
    reset = 0; load = 1; enable = 0; dir = 0;
    serial_in = 0; rotate = 0; parallel_in = 8'hFF;

    // Reset held with a conflicting load
    step(0, 1, 0, 0, 0, 0, 8'hFF);
    step(0, 1, 0, 0, 0, 0, 8'hFF);
    chk("rst_po", int'(po[0]), 0);
    chk("rst_cnt", int'(cnt0), 0);
    chk("rst_fd", int'(fd[0]), 0);
    chk("rst_so", int'(so[0]), 0);

    // Left serialise 8'hA5
    seq = 8'b10100101;
    step(1, 1, 0, 0, 0, 0, 8'hA5);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("ser_bit%0d", k), int'(so[0]), int'(seq[7-k]));
      chk("ser_nofd", int'(fd[0]), 0);
      step(1, 0, 1, 0, 0, 0, 8'h00);
    end
    chk("ser_po", int'(po[0]), 8'h00);
    chk("ser_fd", int'(fd[0]), 1);
    step(1, 0, 0, 0, 0, 0, 8'h00);
    chk("ser_fd_end", int'(fd[0]), 0);

    // Right deserialise 1,1,0,1,0,0,1,0
    din = 8'b01001011;
    step(1, 1, 0, 1, 0, 0, 8'h00);
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      step(1, 0, 1, 1, din[k], 0, 8'h00);
      chk("des_cnt", int'(cnt0), (k + 1) % 8);
      pulses += int'(fd[0]);
    end
    chk("des_po", int'(po[0]), 8'h4B);
    chk("des_pulses", pulses, 1);

    // Load wins over enable mid-frame, then reset discards a partial frame
    for (int k = 0; k < 5; k++) step(1, 0, 1, 0, 1, 0, 8'h00);
    step(1, 1, 1, 0, 1, 0, 8'h3C);
    chk("ld_po", int'(po[0]), 8'h3C);
    chk("ld_cnt", int'(cnt0), 0);
    chk("ld_fd", int'(fd[0]), 0);
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 1, 1, 0, 0, 8'h00);
      pulses += int'(fd[0]);
    end
    step(0, 0, 1, 1, 0, 0, 8'h00);
    pulses += int'(fd[0]);
    chk("rst_mid_cnt", int'(cnt0), 0);
    chk("rst_mid_pulses", pulses, 0);

    // FRAME_LEN=3: 7 shifts pulse twice, end on count 1
    step(1, 1, 0, 0, 0, 0, 8'h5A);
    pulses = 0;
    for (int k = 0; k < 7; k++) begin
      step(1, 0, 1, k[0], 1, 0, 8'h00);
      pulses += int'(fd[1]);
      if (k == 2 || k == 5) chk("f3_pulse", int'(fd[1]), 1);
    end
    chk("f3_pulses", pulses, 2);
    chk("f3_cnt", int'(cnt1), 1);
    chk("f1_fd", int'(fd[2]), 1);
    chk("f1_cnt", int'(cnt2), 0);

`ifdef SHIFT_ROTATE_EN
    step(1, 1, 0, 0, 0, 1, 8'h81);
    step(1, 0, 1, 0, 0, 1, 8'h00);
    chk("rot_one", int'(po[0]), 8'h03);
    for (int k = 0; k < 7; k++) step(1, 0, 1, 0, k[0], 1, 8'h00);
    chk("rot_full", int'(po[0]), 8'h81);
`endif

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 99) >= 4) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 10) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 75) ? 1'b1 : 1'b0,
           1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_reg_universal.md
# shift_reg_universal

Parametrised bidirectional shift register with parallel load, frame counting and an optional rotate mode. Serves as the general-purpose serialiser/deserialiser for serial links: loads a parallel word and shifts it out, or shifts serial data in and exposes it as a parallel word. A one-cycle `frame_done` pulse marks every FRAME_LEN completed shifts.

## Interface

- `WIDTH`, 8, register width in bits; legal range 2 or more.
- `FRAME_LEN`, WIDTH, number of shifts per frame; legal range 1 or more.
- `clk`  input  1  rising-edge clock; the only clock.
- `reset`  input  1  synchronous, active-low reset.
- `enable`  input  1  perform one shift this cycle.
- `dir`  input  1  0 = shift left (towards MSB), 1 = shift right (towards LSB).
- `load`  input  1  parallel load this cycle.
- `parallel_in`  input  WIDTH  word captured on `load`.
- `serial_in`  input  1  bit entering the vacated end on a shift.
- `rotate`  input  1  present only with `SHIFT_ROTATE_EN`; see Configuration.
- `serial_out`  output  1  bit at the leading end: `register[WIDTH-1]` if `dir`=0, `register[0]` if `dir`=1; combinational from register and `dir`.
- `parallel_out`  output  WIDTH  current register contents.
- `count`  output  CW  shifts completed in the current frame; CW = max(1, $clog2(FRAME_LEN)).
- `frame_done`  output  1  registered one-cycle pulse.

## Operation

- Priority per rising edge: reset, then load, then enable, then hold.
- Reset (`reset`=0): register is set to 0, `count` to 0 and `frame_done` to 0. The other inputs are ignored. While reset is held, `serial_out` is 0.
- Load (`load`=1): register takes `parallel_in` and `count` is cleared to 0. `enable` is ignored in the same cycle, and no `frame_done` is produced.
- Shift left (`enable`=1, `dir`=0): register becomes {register[WIDTH-2:0], serial_in}.
- Shift right (`enable`=1, `dir`=1): register becomes {serial_in, register[WIDTH-1:1]}.
- Frame counter:
  - Increments on every shift.
  - When a shift occurs with `count` = FRAME_LEN-1, `count` wraps to 0 and `frame_done` is 1 in the following cycle only.
  - With FRAME_LEN=1, every shift pulses `frame_done` and `count` stays 0.
- Hold (`enable`=0, `load`=0): register and `count` are unchanged, and `frame_done` is 0.
- `dir` may change on any cycle. It does not clear `count`.
- A reset mid-frame discards the partial frame; no pulse is produced.

## Timing

- All state updates occur on the rising edge of `clk`.
- `parallel_out` and `count` reflect an operation 1 cycle after the edge that samples it.
- `serial_out` is valid in the same cycle that `register` or `dir` changes. There is no extra register stage.
- `frame_done` asserts in the cycle after the FRAME_LEN-th shift edge and lasts exactly 1 cycle. Back-to-back frames with FRAME_LEN=1 keep it high continuously while `enable`=1.
- Loading an N-bit word and shifting it out fully takes 1 load cycle plus WIDTH shift cycles.
- No combinational path from `serial_in`, `enable` or `load` to any output.

## Configuration

- Macro: `SHIFT_ROTATE_EN`.
- Defined:
  - The `rotate` input port exists.
  - On a shift with `rotate`=1, the bit entering the vacated end is the bit leaving the other end (`register[WIDTH-1]` for left, `register[0]` for right), and `serial_in` is ignored.
  - With `rotate`=0, behaviour is identical to the undefined case.
  - Counting and `frame_done` are unaffected by rotation.
- Undefined: there is no `rotate` port, and the shift-in bit is always `serial_in`.

## Test plan

- Reset: drive `reset`=0 for 2 cycles with `load`=1, `parallel_in`=8'hFF -> `parallel_out`=8'h00, `count`=0, `frame_done`=0, `serial_out`=0.
- Left serialise (WIDTH=8): load 8'hA5, then 8 shifts with `dir`=0, `serial_in`=0 -> `serial_out` sequence 1,0,1,0,0,1,0,1; final `parallel_out`=8'h00; `frame_done` high only in the cycle after shift 8.
- Right deserialise: shift in bits 1,1,0,1,0,0,1,0 with `dir`=1 -> `parallel_out`=8'h4B; `count` steps 1..7 then 0; one `frame_done` pulse.
- Load/enable conflict: after 5 shifts, assert `load`=1 and `enable`=1 together with 8'h3C -> `parallel_out`=8'h3C, `count`=0, no pulse. Then 3 shifts followed by reset=0 -> `count`=0 and no pulse ever.
- FRAME_LEN=3, WIDTH=8, 7 consecutive shifts -> `frame_done` pulses after shifts 3 and 6; `count`=1 at the end.
- With `SHIFT_ROTATE_EN`: load 8'h81, `rotate`=1, `dir`=0, 1 shift -> 8'h03; 8 shifts from 8'h81 -> 8'h81 again regardless of `serial_in`.
